// File: rtl/par_mul_pkg.sv
// par_mul_pkg: shared types and helpers for the parallel multiplier array.
// Contents:
//   state_e  - controller state encoding (IDLE, RUN, DONE)
//   calc_rw  - per-lane result width, derived from WIDTH and FULL_PROD
//   lane_lo  - low bit index of a lane inside a flat, lane-packed bus
package par_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Result width per lane: the full 2*WIDTH product or only its low WIDTH bits.
    function automatic int calc_rw(input int width, input int full_prod);
        return (full_prod != 0) ? 2 * width : width;
    endfunction

    // Lane i of a flat bus occupies bits [lane_lo(i, w) +: w].
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/par_mul_array_if.sv
// par_mul_array_if: launch/result bundle of the parallel multiplier array.
// Signals:
//   start     - launch request, sampled only while the array is idle
//   lane_en   - per-lane enable, captured with start
//   a_flat    - operand A, lane i at [i*WIDTH +: WIDTH]
//   b_flat    - operand B, same packing as a_flat
//   x_flat    - held results, lane i at [i*RW +: RW]
//   valid     - one-cycle pulse when every enabled lane has finished
//   busy      - high while an operation is running
//   lane_done - per-lane completion flags of the current operation
// Modports: master drives the request side, slave is the multiplier array.
interface par_mul_array_if #(
    parameter int N_LANES = 5,
    parameter int WIDTH   = 32,
    parameter int RW      = 32
);
    logic                       start;
    logic [N_LANES-1:0]         lane_en;
    logic [N_LANES*WIDTH-1:0]   a_flat;
    logic [N_LANES*WIDTH-1:0]   b_flat;
    logic [N_LANES*RW-1:0]      x_flat;
    logic                       valid;
    logic                       busy;
    logic [N_LANES-1:0]         lane_done;

    modport master (
        output start, lane_en, a_flat, b_flat,
        input  x_flat, valid, busy, lane_done
    );

    modport slave (
        input  start, lane_en, a_flat, b_flat,
        output x_flat, valid, busy, lane_done
    );
endinterface

// File: rtl/seq_mul_lane.sv
// seq_mul_lane: one sequential shift-add multiplier lane.
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   go         - launch pulse; captures en, a and b
//   en         - lane enable; a disabled lane finishes at once with result 0
//   a, b       - operands (two's-complement when SIGNED=1)
//   prod       - product (low WIDTH bits, or all 2*WIDTH bits when FULL_PROD=1)
//   done       - lane finished; held until the next go or reset
// Build option: PAR_MUL_EARLY_TERM_EN lets a lane finish as soon as its
// remaining multiplier bits are all zero instead of always running WIDTH steps.
module seq_mul_lane
    import par_mul_pkg::*;
#(
    parameter  int WIDTH     = 32,
    parameter  int SIGNED    = 0,
    parameter  int FULL_PROD = 0,
    localparam int RW        = calc_rw(WIDTH, FULL_PROD)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [RW-1:0]    prod,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH:0]   w_a_ext;
    logic [WIDTH:0]   w_b_ext;
    logic [WIDTH:0]   w_a_mag;
    logic [WIDTH:0]   w_b_mag;
    logic [WIDTH:0]   w_mplier_nxt;
    logic             w_zero_entry;
    logic             w_last;

    logic             r_en;
    logic             r_neg;
    logic             r_active;
    logic             r_done;
    logic [RW-1:0]    r_acc;
    logic [RW-1:0]    r_mcand;
    logic [WIDTH:0]   r_mplier;
    logic [CW-1:0]    r_cnt;

    // Magnitudes are WIDTH+1 bits so that the most negative operand negates
    // without overflow; the top bit of a magnitude is therefore always zero.
    assign w_a_neg = (SIGNED != 0) && a[WIDTH-1];
    assign w_b_neg = (SIGNED != 0) && b[WIDTH-1];
    assign w_a_ext = {w_a_neg, a};
    assign w_b_ext = {w_b_neg, b};
    assign w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
    assign w_b_mag = w_b_neg ? -w_b_ext : w_b_ext;

    assign w_mplier_nxt = r_mplier >> 1;

`ifdef PAR_MUL_EARLY_TERM_EN
    assign w_zero_entry = (w_b_mag == '0);
    assign w_last       = (r_cnt == CW'(WIDTH - 1)) || (w_mplier_nxt == '0);
`else
    assign w_zero_entry = 1'b0;
    assign w_last       = (r_cnt == CW'(WIDTH - 1));
`endif

    // NOTE: the datapath registers are reset as well as the control bits, so a
    // reset mid-operation leaves nothing behind that could leak into prod.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en     <= 1'b0;
            r_neg    <= 1'b0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (go) begin
            r_en     <= en;
            r_neg    <= w_a_neg ^ w_b_neg;
            r_acc    <= '0;
            r_mcand  <= RW'(w_a_mag);
            r_mplier <= w_b_mag;
            r_cnt    <= '0;
            r_done   <= !en || w_zero_entry;
            r_active <= en && !w_zero_entry;
        end else if (r_active) begin
            // r_mcand holds A << step, so each step adds the shifted multiplicand.
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= w_mplier_nxt;
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                r_active <= 1'b0;
                r_done   <= 1'b1;
            end
        end
    end

    // Low bits of a two's-complement negation are the same at any width, so the
    // sign fixup is valid for both the truncated and the full-width product.
    assign prod = !r_en ? '0 : (r_neg ? -r_acc : r_acc);
    assign done = r_done;

endmodule

// File: rtl/par_mul_array.sv
// par_mul_array: N_LANES parallel sequential multipliers behind one start.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous active-high reset; discards any operation in flight
//   bus   - par_mul_array_if.slave: start/lane_en/a_flat/b_flat in,
//           x_flat/valid/busy/lane_done out
// Parameters: N_LANES, WIDTH, SIGNED (two's-complement operands), FULL_PROD
// (2*WIDTH-bit results). Build option PAR_MUL_EARLY_TERM_EN enables per-lane
// early termination; results are identical either way, only latency differs.
module par_mul_array
    import par_mul_pkg::*;
#(
    parameter int N_LANES   = 5,
    parameter int WIDTH     = 32,
    parameter int SIGNED    = 0,
    parameter int FULL_PROD = 0
) (
    input  logic            clk,
    input  logic            reset,
    par_mul_array_if.slave  bus
);
    localparam int RW = calc_rw(WIDTH, FULL_PROD);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]              r_state;
    logic [N_LANES*RW-1:0]   r_x;
    logic                    w_go;
    logic [N_LANES-1:0]      w_lane_done;
    logic [N_LANES*RW-1:0]   w_prod;

    // A start is taken only in IDLE; in RUN and DONE it is dropped, not queued.
    assign w_go = (r_state == S_IDLE) && bus.start;

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        seq_mul_lane #(
            .WIDTH     (WIDTH),
            .SIGNED    (SIGNED),
            .FULL_PROD (FULL_PROD)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .go    (w_go),
            .en    (bus.lane_en[i]),
            .a     (bus.a_flat[lane_lo(i, WIDTH) +: WIDTH]),
            .b     (bus.b_flat[lane_lo(i, WIDTH) +: WIDTH]),
            .prod  (w_prod[lane_lo(i, RW) +: RW]),
            .done  (w_lane_done[i])
        );
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_x     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // All lanes commit together so x_flat never shows a mix of
                    // old and new results.
                    if (&w_lane_done) begin
                        r_x     <= w_prod;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.x_flat    = r_x;
    assign bus.valid     = (r_state == S_DONE);
    assign bus.busy      = (r_state == S_RUN);
    assign bus.lane_done = w_lane_done;

endmodule

// File: tb/tb_par_mul_array.sv
// tb_par_mul_array: self-checking bench for par_mul_array.
// dut0: default parameters (5 lanes, 32-bit, unsigned, truncated result).
// dut1: 2 lanes, 8-bit, signed, full 16-bit product.
// Expected results are pushed to a scoreboard queue when an operation is
// launched and popped when the DUT raises valid.
module tb_par_mul_array;
    import par_mul_pkg::*;

    localparam int N     = 5;
    localparam int W     = 32;
    localparam int RW0   = W;
    localparam int N1    = 2;
    localparam int W1    = 8;
    localparam int RW1   = 16;
    localparam int LIMIT = 100;

    typedef logic [N*RW0-1:0]  x0_t;
    typedef logic [N1*RW1-1:0] x1_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    par_mul_array_if #(.N_LANES(N),  .WIDTH(W),  .RW(RW0)) bus0 ();
    par_mul_array_if #(.N_LANES(N1), .WIDTH(W1), .RW(RW1)) bus1 ();

    par_mul_array #(.N_LANES(N), .WIDTH(W), .SIGNED(0), .FULL_PROD(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    par_mul_array #(.N_LANES(N1), .WIDTH(W1), .SIGNED(1), .FULL_PROD(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    int  total = 0;
    int  bad   = 0;
    x0_t sb0[$];
    x1_t sb1[$];

    // ---------------- reference models ----------------
    function automatic x0_t model0(input logic [N-1:0] en, input logic [N*W-1:0] a,
                                   input logic [N*W-1:0] b);
        x0_t r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            logic [W-1:0] p;
            p = a[i*W +: W] * b[i*W +: W];
            r[i*RW0 +: RW0] = en[i] ? p : '0;
        end
        return r;
    endfunction

    function automatic x1_t model1(input logic [N1*W1-1:0] a, input logic [N1*W1-1:0] b);
        x1_t r;
        r = '0;
        for (int i = 0; i < N1; i++) begin
            logic signed [W1-1:0]  ai;
            logic signed [W1-1:0]  bi;
            logic signed [RW1-1:0] p;
            ai = a[i*W1 +: W1];
            bi = b[i*W1 +: W1];
            p  = ai * bi;
            r[i*RW1 +: RW1] = p;
        end
        return r;
    endfunction

    // Edge count from the accepting edge to the edge that enters DONE.
    function automatic int exp_lat0(input logic [N-1:0] en, input logic [N*W-1:0] b);
        int worst;
        worst = 0;
`ifdef PAR_MUL_EARLY_TERM_EN
        for (int i = 0; i < N; i++) begin
            if (en[i]) begin
                logic [W-1:0] bi;
                bi = b[i*W +: W];
                for (int j = 0; j < W; j++) begin
                    if (bi[j] && (j + 1) > worst) worst = j + 1;
                end
            end
        end
`else
        if (en != '0) worst = W;
`endif
        return worst + 1;
    endfunction

    // ---------------- drivers (caller is at a falling edge) ----------------
    task automatic op0(input logic [N-1:0] en, input logic [N*W-1:0] a,
                       input logic [N*W-1:0] b, output int lat, output x0_t x,
                       output logic [N-1:0] ld_first, output logic [N-1:0] ld,
                       output logic busy_ok, output logic post_v, output logic post_b);
        bus0.start   = 1'b1;
        bus0.lane_en = en;
        bus0.a_flat  = a;
        bus0.b_flat  = b;
        sb0.push_back(model0(en, a, b));
        @(posedge clk);
        @(negedge clk);
        bus0.start = 1'b0;
        busy_ok  = bus0.busy;
        ld_first = bus0.lane_done;
        lat      = -1;
        for (int c = 1; c <= LIMIT; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus0.valid) begin
                lat = c;
                break;
            end
            if (!bus0.busy) busy_ok = 1'b0;
        end
        x  = bus0.x_flat;
        ld = bus0.lane_done;
        @(negedge clk);
        post_v = bus0.valid;
        post_b = bus0.busy;
    endtask

    task automatic op1(input logic [N1*W1-1:0] a, input logic [N1*W1-1:0] b,
                       output int lat, output x1_t x);
        bus1.start   = 1'b1;
        bus1.lane_en = '1;
        bus1.a_flat  = a;
        bus1.b_flat  = b;
        sb1.push_back(model1(a, b));
        @(posedge clk);
        @(negedge clk);
        bus1.start = 1'b0;
        lat = -1;
        for (int c = 1; c <= LIMIT; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus1.valid) begin
                lat = c;
                break;
            end
        end
        x = bus1.x_flat;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        total++; if (bus0.x_flat !== '0) begin bad++; $display("FAIL reset_x got=%h exp=0", bus0.x_flat); end
        total++; if (bus0.valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus0.valid); end
        total++; if (bus0.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus0.busy); end
        total++; if (bus0.lane_done !== '0) begin bad++; $display("FAIL reset_lane_done got=%b exp=0", bus0.lane_done); end
        total++; if (bus1.x_flat !== '0) begin bad++; $display("FAIL reset_x1 got=%h exp=0", bus1.x_flat); end
    endtask

    task automatic test_basic();
        logic [N*W-1:0] a, b;
        int lat; x0_t x, exp; logic [N-1:0] ldf, ld; logic bok, pv, pb;
        for (int i = 0; i < N; i++) begin
            a[i*W +: W] = W'(i + 3);
            b[i*W +: W] = 32'd7;
        end
        op0('1, a, b, lat, x, ldf, ld, bok, pv, pb);
        exp = sb0.pop_front();
        total++; if (x !== exp) begin bad++; $display("FAIL basic_x got=%h exp=%h", x, exp); end
        total++; if (x[0 +: W] !== 32'd21) begin bad++; $display("FAIL basic_lane0 got=%0d exp=21", x[0 +: W]); end
        total++; if (lat !== exp_lat0('1, b)) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", lat, exp_lat0('1, b)); end
        total++; if (bok !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", bok); end
        total++; if (ld !== '1) begin bad++; $display("FAIL basic_lane_done got=%b exp=11111", ld); end
        total++; if (pv !== 1'b0 || pb !== 1'b0) begin bad++; $display("FAIL basic_after_done got=v%b/b%b exp=v0/b0", pv, pb); end
    endtask

    task automatic test_mask();
        logic [N*W-1:0] a, b;
        logic [N-1:0] en;
        int lat; x0_t x, exp; logic [N-1:0] ldf, ld; logic bok, pv, pb;
        en = 5'b10101;
        for (int i = 0; i < N; i++) begin
            a[i*W +: W] = $urandom();
            b[i*W +: W] = $urandom() | 32'h1;
        end
        op0(en, a, b, lat, x, ldf, ld, bok, pv, pb);
        exp = sb0.pop_front();
        total++; if (x !== exp) begin bad++; $display("FAIL mask_x got=%h exp=%h", x, exp); end
        total++; if (x[1*W +: W] !== '0 || x[3*W +: W] !== '0) begin bad++; $display("FAIL mask_zero_lanes got=%h/%h exp=0/0", x[1*W +: W], x[3*W +: W]); end
        total++; if (ldf !== ~en) begin bad++; $display("FAIL mask_first_lane_done got=%b exp=%b", ldf, ~en); end
        total++; if (ld !== '1) begin bad++; $display("FAIL mask_lane_done got=%b exp=11111", ld); end
        total++; if (lat !== exp_lat0(en, b)) begin bad++; $display("FAIL mask_latency got=%0d exp=%0d", lat, exp_lat0(en, b)); end
    endtask

    task automatic test_signed();
        logic [7:0] tab_a [6] = '{8'h80, 8'hFF, 8'h80, 8'h7F, 8'h00, 8'h81};
        logic [7:0] tab_b [6] = '{8'h80, 8'h02, 8'h7F, 8'h7F, 8'h80, 8'hFF};
        int lat; x1_t x, exp;
        // Fixed corner cases, two per operation.
        for (int k = 0; k < 6; k += 2) begin
            op1({tab_a[k+1], tab_a[k]}, {tab_b[k+1], tab_b[k]}, lat, x);
            exp = sb1.pop_front();
            total++; if (x !== exp) begin bad++; $display("FAIL signed_tab%0d got=%h exp=%h", k, x, exp); end
            if (k == 0) begin
                total++; if (x !== {16'hFFFE, 16'h4000}) begin bad++; $display("FAIL signed_corner got=%h exp=fffe4000", x); end
            end
            total++; if (lat < 0) begin bad++; $display("FAIL signed_timeout got=%0d exp=>0", lat); end
        end
        for (int k = 0; k < 4; k++) begin
            op1(16'($urandom()), 16'($urandom()), lat, x);
            exp = sb1.pop_front();
            total++; if (x !== exp) begin bad++; $display("FAIL signed_rand%0d got=%h exp=%h", k, x, exp); end
        end
    endtask

    task automatic test_restart();
        logic [N*W-1:0] a, b;
        int nv; x0_t x, exp;
        for (int i = 0; i < N; i++) begin
            a[i*W +: W] = $urandom();
            b[i*W +: W] = $urandom() | 32'h8000_0000;
        end
        bus0.start = 1'b1; bus0.lane_en = '1; bus0.a_flat = a; bus0.b_flat = b;
        sb0.push_back(model0('1, a, b));
        @(posedge clk);
        @(negedge clk);
        bus0.start = 1'b0;
        nv = 0;
        x  = '0;
        for (int c = 1; c <= W + 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus0.valid) begin
                nv++;
                x = bus0.x_flat;
            end
            if (c == 5) begin
                bus0.start  = 1'b1;
                bus0.a_flat = {N{32'h1234_5678}};
                bus0.b_flat = {N{32'h0000_0003}};
            end else begin
                bus0.start = 1'b0;
            end
        end
        exp = sb0.pop_front();
        total++; if (nv !== 1) begin bad++; $display("FAIL restart_valid_count got=%0d exp=1", nv); end
        total++; if (x !== exp) begin bad++; $display("FAIL restart_x got=%h exp=%h", x, exp); end
    endtask

    task automatic test_reset_mid();
        logic [N*W-1:0] a, b;
        int nv, lat; x0_t x, exp; logic [N-1:0] ldf, ld; logic bok, pv, pb;
        for (int i = 0; i < N; i++) begin
            a[i*W +: W] = $urandom();
            b[i*W +: W] = $urandom() | 32'h8000_0000;
        end
        bus0.start = 1'b1; bus0.lane_en = '1; bus0.a_flat = a; bus0.b_flat = b;
        sb0.push_back(model0('1, a, b));
        @(posedge clk);
        @(negedge clk);
        bus0.start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        void'(sb0.pop_front());
        total++; if (bus0.x_flat !== '0) begin bad++; $display("FAIL midreset_x got=%h exp=0", bus0.x_flat); end
        total++; if (bus0.busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b exp=0", bus0.busy); end
        total++; if (bus0.valid !== 1'b0) begin bad++; $display("FAIL midreset_valid got=%b exp=0", bus0.valid); end
        total++; if (bus0.lane_done !== '0) begin bad++; $display("FAIL midreset_lane_done got=%b exp=0", bus0.lane_done); end
        nv = 0;
        for (int c = 0; c < W + 5; c++) begin
            @(negedge clk);
            if (bus0.valid) nv++;
        end
        total++; if (nv !== 0) begin bad++; $display("FAIL midreset_stale_valid got=%0d exp=0", nv); end
        op0('1, a, b, lat, x, ldf, ld, bok, pv, pb);
        exp = sb0.pop_front();
        total++; if (x !== exp) begin bad++; $display("FAIL midreset_rerun_x got=%h exp=%h", x, exp); end
        total++; if (lat !== exp_lat0('1, b)) begin bad++; $display("FAIL midreset_rerun_latency got=%0d exp=%0d", lat, exp_lat0('1, b)); end
    endtask

    task automatic test_back_to_back();
        logic [N*W-1:0] a, b;
        logic [N-1:0] en;
        int lat; x0_t x, exp; logic [N-1:0] ldf, ld; logic bok, pv, pb;
        for (int k = 0; k < 3; k++) begin
            en = N'($urandom()) | 5'b00001;
            for (int i = 0; i < N; i++) begin
                a[i*W +: W] = $urandom();
                b[i*W +: W] = $urandom() | 32'h1;
            end
            op0(en, a, b, lat, x, ldf, ld, bok, pv, pb);
            exp = sb0.pop_front();
            total++; if (x !== exp) begin bad++; $display("FAIL b2b%0d_x got=%h exp=%h", k, x, exp); end
            total++; if (lat !== exp_lat0(en, b)) begin bad++; $display("FAIL b2b%0d_latency got=%0d exp=%0d", k, lat, exp_lat0(en, b)); end
        end
        // Idle with start low: results and flags hold.
        repeat (5) @(negedge clk);
        total++; if (bus0.x_flat !== exp) begin bad++; $display("FAIL idle_hold_x got=%h exp=%h", bus0.x_flat, exp); end
        total++; if (bus0.lane_done !== '1) begin bad++; $display("FAIL idle_hold_lane_done got=%b exp=11111", bus0.lane_done); end
    endtask

    task automatic test_latency();
        logic [N*W-1:0] a, b;
        int lat; x0_t x, exp; logic [N-1:0] ldf, ld; logic bok, pv, pb;
        for (int i = 0; i < N; i++) begin
            a[i*W +: W] = $urandom();
            b[i*W +: W] = 32'd1;
        end
        op0('1, a, b, lat, x, ldf, ld, bok, pv, pb);
        exp = sb0.pop_front();
        total++; if (x !== exp) begin bad++; $display("FAIL lat_b1_x got=%h exp=%h", x, exp); end
        total++; if (lat !== exp_lat0('1, b)) begin bad++; $display("FAIL lat_b1 got=%0d exp=%0d", lat, exp_lat0('1, b)); end
        b[2*W +: W] = 32'h8000_0000;
        op0('1, a, b, lat, x, ldf, ld, bok, pv, pb);
        exp = sb0.pop_front();
        total++; if (x !== exp) begin bad++; $display("FAIL lat_msb_x got=%h exp=%h", x, exp); end
        total++; if (lat !== W + 1) begin bad++; $display("FAIL lat_msb got=%0d exp=%0d", lat, W + 1); end
        op0('0, a, b, lat, x, ldf, ld, bok, pv, pb);
        exp = sb0.pop_front();
        total++; if (x !== '0 || exp !== '0) begin bad++; $display("FAIL lat_none_x got=%h exp=0", x); end
        total++; if (lat !== 1) begin bad++; $display("FAIL lat_none got=%0d exp=1", lat); end
        total++; if (ldf !== '1) begin bad++; $display("FAIL lat_none_lane_done got=%b exp=11111", ldf); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        bus0.start   = 1'b0;
        bus0.lane_en = '0;
        bus0.a_flat  = '0;
        bus0.b_flat  = '0;
        bus1.start   = 1'b0;
        bus1.lane_en = '0;
        bus1.a_flat  = '0;
        bus1.b_flat  = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_mask();
        test_signed();
        test_restart();
        test_reset_mid();
        test_back_to_back();
        test_latency();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
